mem_stage: RTL



---
 rtl/mem_pkg.sv | 17 +
 rtl/mw_latch.sv | 33 +++
 rtl/mem_stage.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: FSM encoding, width defaults
// and the MMIO decode constants used when MEM_MMIO_EN is defined.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } memStateT;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    localparam int         MMIO_SEL_BIT = 31;
    localparam logic [0:0] MMIO_IDX_IN  = 1'b0;
    localparam logic [0:0] MMIO_IDX_REG = 1'b1;

endpackage

// File: rtl/mw_latch.sv
// M/W pipeline latch feeding register writeback; a held or bubbled cycle never
// produces a register write.
module mw_latch #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              loadEn,
    input  logic              bubble,
    input  logic [DATA_W-1:0] dataIn,
    input  logic [4:0]        rdIn,
    input  logic              wRegIn,
    output logic [DATA_W-1:0] wbData,
    output logic [4:0]        wbRd,
    output logic              wbWReg
);

    always_ff @(posedge clock) begin
        if (reset) begin
            wbData <= '0;
            wbRd   <= '0;
            wbWReg <= 1'b0;
        end else begin
            if (loadEn) begin
                wbData <= dataIn;
                wbRd   <= rdIn;
            end
            // r0 is hardwired to zero, so a write to it is dropped here
            wbWReg <= loadEn & ~bubble & wRegIn & (rdIn != 5'd0);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack handshake to a multi-cycle data memory, upstream
// stall generation and the M/W latch. Define MEM_MMIO_EN for the internal MMIO window.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] oIn,
    input  logic [DATA_W-1:0] dIn,
    input  logic              wMemIn,
    input  logic              wRegIn,
    input  logic              lwIn,
    input  logic [4:0]        rdIn,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRdata,
    output logic              stall,
    output logic [DATA_W-1:0] wbData,
    output logic [4:0]        wbRd,
    output logic              wbWReg
`ifdef MEM_MMIO_EN
    ,
    input  logic [DATA_W-1:0] ioIn,
    output logic [DATA_W-1:0] ioOut
`endif
);

    memStateT          state;
    logic              rstHold;
    logic              isMmio;
    logic              memAccess;
    logic [DATA_W-1:0] loadData;
    logic [DATA_W-1:0] wbNext;

`ifdef MEM_MMIO_EN
    logic [DATA_W-1:0] ioReg;
    assign isMmio = oIn[MMIO_SEL_BIT];
    assign ioOut  = ioReg;
`else
    assign isMmio = 1'b0;
`endif

    assign memAccess = (wMemIn | lwIn) & ~isMmio;

    // rstHold masks the first cycle after reset, when X/M may still carry the abandoned op
    assign memReq   = memAccess & ~rstHold;
    assign memWe    = wMemIn;
    assign memAddr  = oIn[ADDR_W-1:0];
    assign memWdata = dIn;
    assign stall    = (state == BUSY) ? ~memAck : memReq;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            rstHold <= 1'b1;
        end else begin
            rstHold <= 1'b0;
            case (state)
                IDLE:    if (memReq) state <= BUSY;
                BUSY:    if (memAck) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_MMIO_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            ioReg <= '0;
        end else if (~rstHold && state == IDLE && wMemIn && isMmio
                     && oIn[0] == MMIO_IDX_REG) begin
            ioReg <= dIn;
        end
    end

    always_comb begin
        loadData = memRdata;
        if (isMmio) begin
            loadData = (oIn[0] == MMIO_IDX_REG) ? ioReg : ioIn;
        end
    end
`else
    assign loadData = memRdata;
`endif

    assign wbNext = lwIn ? loadData : oIn;

    mw_latch #(
        .DATA_W(DATA_W)
    ) uMwLatch (
        .clock (clock),
        .reset (reset),
        .loadEn(~stall),
        .bubble(rstHold),
        .dataIn(wbNext),
        .rdIn  (rdIn),
        .wRegIn(wRegIn),
        .wbData(wbData),
        .wbRd  (wbRd),
        .wbWReg(wbWReg)
    );

endmodule
